data_mem_responder: RTL and testbench
=====================================

# data_mem_responder

Multi-cycle data-memory responder serving the MEM stage of the MIPS pipeline. Accepts one load/store request at a time over a valid/ready handshake, performs the access after a programmable latency, and returns a single-cycle response. Drives `busy` so the hazard logic can hold PC, IF/ID and the downstream stages while an access is outstanding.

## Interface
- `DEPTH_WORDS`, 256, number of 32-bit words; power of two, ≥ 2.
- `LATENCY`, 2, edges from accept to response; ≥ 1.

- `clk`  in  1  single clock, rising edge.
- `reset`  in  1  synchronous, active-high.
- `req_valid`  in  1  request present.
- `req_ready`  out  1  responder can accept; combinational, high only in IDLE with `reset` low.
- `req_write`  in  1  1 = store, 0 = load.
- `req_addr`  in  32  byte address.
- `req_wdata`  in  32  store data.
- `req_byte_en`  in  4  store lane enables; bit i covers bits 8i+7:8i. Ignored for loads.
- `resp_valid`  out  1  response strobe, one cycle, registered.
- `resp_rdata`  out  32  load data, registered; 0 for stores and errors.
- `resp_error`  out  1  misaligned or out-of-range access, registered.
- `busy`  out  1  stall request to the pipeline, combinational.

## Operation
- States: IDLE, WAIT, RESP.
- IDLE: when `req_valid` is high on an edge, latch write, addr, wdata and byte_en; set `cnt = LATENCY-1`; go to WAIT.
- WAIT: on each edge, if `cnt != 0`, decrement `cnt`; otherwise perform the access, register the response, and go to RESP.
- RESP: `resp_valid = 1` for exactly one cycle, then IDLE. No response backpressure.
- Requests are never accepted in WAIT or RESP. `req_valid` is ignored in those states.
- Word index = `addr[log2(DEPTH_WORDS)+1:2]`.
- Error when `addr[1:0] != 0` or any of `addr[31:log2(DEPTH_WORDS)+2]` is nonzero. On error: memory is untouched, `resp_rdata = 0`, `resp_error = 1`.
- Store: update only the enabled lanes. `byte_en = 0` is a legal no-op with no error. `resp_rdata = 0`.
- Load: full word, independent of `byte_en`.
- `busy = (state == WAIT) | (state == IDLE & req_valid)`. `busy` is low in RESP so the pipeline advances and captures `resp_rdata` in that cycle.

## Timing
- Reset values: state IDLE, `cnt = 0`, `resp_valid = 0`, `resp_rdata = 0`, `resp_error = 0`.
- While `reset` is high: `req_ready = 0` and `busy = 0`.
- Memory array contents are not cleared by reset.
- If a request is accepted at edge E, the access commits at edge E+LATENCY.
- `resp_valid` is high in the cycle between edges E+LATENCY and E+LATENCY+1.
- The next request can be accepted at edge E+LATENCY+2. Maximum throughput is one access per LATENCY+2 cycles.
- `resp_rdata` and `resp_error` are valid only while `resp_valid` is high. They are held at 0 in all other cycles.
- Reset asserted in WAIT aborts the access: no write commits and no `resp_valid` is produced. If reset and the commit edge coincide, reset wins.
- Reset in RESP clears `resp_valid` at that edge.
- A load to an address written by the immediately preceding store returns the new data; the store has already committed before the load is accepted.

## Test plan
- LATENCY=2: store 0xDEADBEEF to 0x10 with `byte_en = F`, accept at edge E → `resp_valid` only in the cycle after E+2, `resp_error = 0`, `resp_rdata = 0`. Then load 0x10 → `resp_rdata = 0xDEADBEEF`.
- Store 0x000000AA to 0x10 with `byte_en = 0001`, then load 0x10 → 0xDEADBEAA. Store with `byte_en = 0` → value unchanged, `resp_error = 0`.
- Load 0x12 → `resp_error = 1`, `resp_rdata = 0`. Store 0x55 to 0x400 with DEPTH_WORDS=256 → `resp_error = 1`, and word 0 is unchanged afterwards.
- Store 0x11111111 to 0x20 (which holds 0x0), assert reset during WAIT → no `resp_valid`, `req_ready` stays low while in reset. Then load 0x20 → 0x0.
- Hold `req_valid` high continuously for three loads → accepts spaced LATENCY+2 edges apart, `busy` low only in RESP cycles, exactly three `resp_valid` pulses.
- LATENCY=1: store then load the same address back-to-back → responses at E+1 and E+4, with the load returning the stored data.

Source files
------------

// File: rtl/data_mem_responder.sv
// Multi-cycle data-memory responder for the MEM stage: one load/store in flight,
// response LATENCY edges after accept, busy stalls the pipeline while outstanding.
module data_mem_responder #(
  parameter int DEPTH_WORDS = 256,
  parameter int LATENCY     = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [3:0]  req_byte_en,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_error,
  output logic        busy
);
  localparam int AW = $clog2(DEPTH_WORDS);
  localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  // Misaligned or beyond the implemented word range.
  function automatic logic addrError(input logic [31:0] addr);
    addrError = (addr[1:0] != 2'b00) || ((addr >> (AW + 2)) != 32'd0);
  endfunction

  state_t         state_r;
  state_t         nextState_s;
  logic [CW-1:0]  cnt_r;
  logic           write_r;
  logic [31:0]    addr_r;
  logic [31:0]    wdata_r;
  logic [3:0]     byteEn_r;
  logic           respValid_r;
  logic [31:0]    respRdata_r;
  logic           respError_r;
  logic           commit_s;
  logic           addrErr_s;
  logic [AW-1:0]  wordIdx_s;
  logic [31:0]    mem_r [DEPTH_WORDS];

  // Next-state decode and access-commit qualification.
  always_comb begin
    nextState_s = state_r;
    commit_s    = 1'b0;
    addrErr_s   = addrError(addr_r);
    wordIdx_s   = addr_r[AW+1:2];
    case (state_r)
      ST_IDLE: begin
        if (req_valid) begin
          nextState_s = ST_WAIT;
        end else begin
          nextState_s = ST_IDLE;
        end
      end
      ST_WAIT: begin
        if (cnt_r == CW'(0)) begin
          nextState_s = ST_RESP;
          commit_s    = 1'b1;
        end else begin
          nextState_s = ST_WAIT;
        end
      end
      ST_RESP: nextState_s = ST_IDLE;
      default: nextState_s = ST_IDLE;
    endcase
  end

  // State, request latch, latency counter and registered response.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r     <= ST_IDLE;
      cnt_r       <= CW'(0);
      respValid_r <= 1'b0;
      respRdata_r <= 32'd0;
      respError_r <= 1'b0;
    end else begin
      state_r     <= nextState_s;
      respValid_r <= 1'b0;
      respRdata_r <= 32'd0;
      respError_r <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (req_valid) begin
            write_r  <= req_write;
            addr_r   <= req_addr;
            wdata_r  <= req_wdata;
            byteEn_r <= req_byte_en;
            cnt_r    <= CW'(LATENCY - 1);
          end
        end
        ST_WAIT: begin
          if (cnt_r != CW'(0)) begin
            cnt_r <= cnt_r - CW'(1);
          end else begin
            respValid_r <= 1'b1;
            if (addrErr_s) begin
              respError_r <= 1'b1;
            end else if (!write_r) begin
              respRdata_r <= mem_r[wordIdx_s];
            end
          end
        end
        ST_RESP: cnt_r <= CW'(0);
        default: cnt_r <= CW'(0);
      endcase
    end
  end

  // Store commit; the array is deliberately left out of reset, and reset on the commit edge wins.
  always_ff @(posedge clk) begin
    if (!reset && commit_s && write_r && !addrErr_s) begin
      for (int i = 0; i < 4; i++) begin
        if (byteEn_r[i]) begin
          mem_r[wordIdx_s][8*i +: 8] <= wdata_r[8*i +: 8];
        end
      end
    end
  end

  assign req_ready  = (state_r == ST_IDLE) && !reset;
  assign busy       = !reset && ((state_r == ST_WAIT) || ((state_r == ST_IDLE) && req_valid));
  assign resp_valid = respValid_r;
  assign resp_rdata = respRdata_r;
  assign resp_error = respError_r;
endmodule

// File: tb/tb_data_mem_responder.sv
// Self-checking bench for data_mem_responder: scoreboard of expected responses,
// one task per scenario, LATENCY=2 instance plus a LATENCY=1 instance.
module tb_data_mem_responder;
  logic        clk = 1'b0;
  logic        reset;
  logic        req_write;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [3:0]  req_byte_en;
  logic        valid0, ready0, rv0, err0, busy0;
  logic [31:0] rd0;
  logic        valid1, ready1, rv1, err1, busy1;
  logic [31:0] rd1;

  data_mem_responder #(.DEPTH_WORDS(256), .LATENCY(2)) dut0 (
    .clk(clk), .reset(reset), .req_valid(valid0), .req_ready(ready0),
    .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
    .req_byte_en(req_byte_en), .resp_valid(rv0), .resp_rdata(rd0),
    .resp_error(err0), .busy(busy0)
  );

  data_mem_responder #(.DEPTH_WORDS(256), .LATENCY(1)) dut1 (
    .clk(clk), .reset(reset), .req_valid(valid1), .req_ready(ready1),
    .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
    .req_byte_en(req_byte_en), .resp_valid(rv1), .resp_rdata(rd1),
    .resp_error(err1), .busy(busy1)
  );

  always #5 clk = ~clk;

  int edgeNo = 0;
  always @(posedge clk) edgeNo <= edgeNo + 1;

  // Observation mux: sel picks which instance the stream driver talks to.
  logic        sel = 1'b0;
  logic        obsValid, obsReady, obsRv, obsErr, obsBusy;
  logic [31:0] obsRd;
  assign obsValid = sel ? valid1 : valid0;
  assign obsReady = sel ? ready1 : ready0;
  assign obsRv    = sel ? rv1    : rv0;
  assign obsErr   = sel ? err1   : err0;
  assign obsBusy  = sel ? busy1  : busy0;
  assign obsRd    = sel ? rd1    : rd0;

  typedef struct packed {
    logic [31:0] data;
    logic        err;
  } exp_t;
  exp_t sbQ[$];

  logic        rqW [8];
  logic [31:0] rqA [8];
  logic [31:0] rqD [8];
  logic [3:0]  rqB [8];
  int          accE [8];
  int          rspE [8];
  logic [31:0] gotD [8];
  logic        gotE [8];
  int          nAcc, nResp, protoBad;
  int          nCmp = 0;
  int          nBad = 0;

  task automatic setReq(input int i, input logic w, input logic [31:0] a,
                        input logic [31:0] d, input logic [3:0] b);
    rqW[i] = w; rqA[i] = a; rqD[i] = d; rqB[i] = b;
  endtask

  task automatic pushExp(input logic [31:0] d, input logic e);
    exp_t x;
    x.data = d; x.err = e;
    sbQ.push_back(x);
  endtask

  task automatic setValid(input logic v);
    if (sel) begin valid1 = v; valid0 = 1'b0; end
    else begin valid0 = v; valid1 = 1'b0; end
  endtask

  // Drives n requests with valid held until each is accepted; records accept/response
  // edges and counts handshake violations against a pending-access model.
  task automatic runStream(input int n);
    logic prevRv;
    bit   pending;
    int   tail;
    prevRv = 1'b0; tail = 0;
    nAcc = 0; nResp = 0; protoBad = 0;
    for (int c = 0; c < 80; c++) begin
      @(negedge clk);
      if (nAcc < n) begin
        req_write = rqW[nAcc]; req_addr = rqA[nAcc];
        req_wdata = rqD[nAcc]; req_byte_en = rqB[nAcc];
        setValid(1'b1);
      end else begin
        setValid(1'b0);
      end
      #1;
      if (obsRv === 1'b1) begin
        if (nResp < n) begin
          rspE[nResp] = edgeNo; gotD[nResp] = obsRd; gotE[nResp] = obsErr;
        end else begin
          protoBad++;
        end
        nResp++;
        if (prevRv === 1'b1) protoBad++;
      end else if (obsRd !== 32'd0 || obsErr !== 1'b0) begin
        protoBad++;
      end
      pending = (nAcc > nResp);
      if (obsBusy !== (pending || (!obsRv && obsValid))) protoBad++;
      if (obsReady !== (!pending && !obsRv)) protoBad++;
      if (obsReady === 1'b1 && obsValid === 1'b1 && nAcc < n) begin
        accE[nAcc] = edgeNo + 1;
        nAcc++;
      end
      prevRv = obsRv;
      if (nResp >= n) tail++;
      if (tail > 3) break;
    end
    if (nResp < n) protoBad++;
    setValid(1'b0);
  endtask

  task automatic test_reset();
    reset = 1'b1; valid0 = 1'b0; valid1 = 1'b0;
    req_write = 1'b0; req_addr = 32'd0; req_wdata = 32'd0; req_byte_en = 4'd0;
    repeat (3) @(negedge clk);
    valid0 = 1'b1; #1;
    nCmp++;
    if ({ready0, busy0, rv0, err0, rd0} !== 36'd0) begin
      nBad++;
      $display("FAIL reset_state: ready=%b busy=%b rv=%b err=%b rdata=%h, expected all 0",
               ready0, busy0, rv0, err0, rd0);
    end
    @(negedge clk);
    reset = 1'b0; valid0 = 1'b0; #1;
    nCmp++;
    if ({ready0, busy0} !== 2'b10) begin
      nBad++; $display("FAIL reset_release: ready=%b busy=%b, expected ready=1 busy=0", ready0, busy0);
    end
    valid0 = 1'b1; #1;
    nCmp++;
    if (busy0 !== 1'b1) begin
      nBad++; $display("FAIL idle_busy: busy=%b with valid in IDLE, expected 1", busy0);
    end
    valid0 = 1'b0;
  endtask

  task automatic test_store_load();
    exp_t e;
    sel = 1'b0; sbQ.delete();
    setReq(0, 1'b1, 32'h10, 32'hDEADBEEF, 4'hF); pushExp(32'h0, 1'b0);
    setReq(1, 1'b0, 32'h10, 32'h0, 4'h0);        pushExp(32'hDEADBEEF, 1'b0);
    runStream(2);
    nCmp++;
    if (protoBad !== 0) begin nBad++; $display("FAIL store_load protocol: %0d violations, expected 0", protoBad); end
    for (int i = 0; i < nResp && i < 2; i++) begin
      e = sbQ.pop_front();
      nCmp++;
      if ({gotE[i], gotD[i]} !== {e.err, e.data}) begin
        nBad++; $display("FAIL store_load resp%0d: got err=%b data=%h, expected err=%b data=%h",
                         i, gotE[i], gotD[i], e.err, e.data);
      end
      nCmp++;
      if (rspE[i] - accE[i] !== 2) begin
        nBad++; $display("FAIL store_load latency%0d: got %0d edges, expected 2", i, rspE[i] - accE[i]);
      end
    end
  endtask

  task automatic test_byte_lanes();
    exp_t e;
    sel = 1'b0; sbQ.delete();
    setReq(0, 1'b1, 32'h10, 32'h000000AA, 4'b0001); pushExp(32'h0, 1'b0);
    setReq(1, 1'b0, 32'h10, 32'h0, 4'h0);           pushExp(32'hDEADBEAA, 1'b0);
    setReq(2, 1'b1, 32'h10, 32'hFFFFFFFF, 4'b0000); pushExp(32'h0, 1'b0);
    setReq(3, 1'b0, 32'h10, 32'h0, 4'h0);           pushExp(32'hDEADBEAA, 1'b0);
    setReq(4, 1'b1, 32'h10, 32'h11223344, 4'b1010); pushExp(32'h0, 1'b0);
    setReq(5, 1'b0, 32'h10, 32'h0, 4'h3);           pushExp(32'h11AD33AA, 1'b0);
    runStream(6);
    nCmp++;
    if (protoBad !== 0) begin nBad++; $display("FAIL byte_lanes protocol: %0d violations, expected 0", protoBad); end
    for (int i = 0; i < nResp && i < 6; i++) begin
      e = sbQ.pop_front();
      nCmp++;
      if ({gotE[i], gotD[i]} !== {e.err, e.data}) begin
        nBad++; $display("FAIL byte_lanes resp%0d: got err=%b data=%h, expected err=%b data=%h",
                         i, gotE[i], gotD[i], e.err, e.data);
      end
    end
  endtask

  task automatic test_errors();
    exp_t e;
    sel = 1'b0; sbQ.delete();
    setReq(0, 1'b1, 32'h0,        32'h12345678, 4'hF); pushExp(32'h0, 1'b0);
    setReq(1, 1'b0, 32'h12,       32'h0, 4'h0);        pushExp(32'h0, 1'b1);
    setReq(2, 1'b1, 32'h400,      32'h55, 4'hF);       pushExp(32'h0, 1'b1);
    setReq(3, 1'b0, 32'h80000000, 32'h0, 4'h0);        pushExp(32'h0, 1'b1);
    setReq(4, 1'b1, 32'h2,        32'hFFFFFFFF, 4'hF); pushExp(32'h0, 1'b1);
    setReq(5, 1'b1, 32'h3FC,      32'hA5A5A5A5, 4'hF); pushExp(32'h0, 1'b0);
    setReq(6, 1'b0, 32'h3FC,      32'h0, 4'h0);        pushExp(32'hA5A5A5A5, 1'b0);
    setReq(7, 1'b0, 32'h0,        32'h0, 4'h0);        pushExp(32'h12345678, 1'b0);
    runStream(8);
    nCmp++;
    if (protoBad !== 0) begin nBad++; $display("FAIL errors protocol: %0d violations, expected 0", protoBad); end
    for (int i = 0; i < nResp && i < 8; i++) begin
      e = sbQ.pop_front();
      nCmp++;
      if ({gotE[i], gotD[i]} !== {e.err, e.data}) begin
        nBad++; $display("FAIL errors resp%0d: got err=%b data=%h, expected err=%b data=%h",
                         i, gotE[i], gotD[i], e.err, e.data);
      end
    end
  endtask

  task automatic test_hold_valid();
    exp_t e;
    sel = 1'b0; sbQ.delete();
    setReq(0, 1'b0, 32'h10,  32'h0, 4'h0); pushExp(32'h11AD33AA, 1'b0);
    setReq(1, 1'b0, 32'h0,   32'h0, 4'h0); pushExp(32'h12345678, 1'b0);
    setReq(2, 1'b0, 32'h3FC, 32'h0, 4'h0); pushExp(32'hA5A5A5A5, 1'b0);
    runStream(3);
    nCmp++;
    if (protoBad !== 0 || nResp !== 3) begin
      nBad++; $display("FAIL hold_valid protocol: %0d violations, %0d pulses, expected 0 and 3", protoBad, nResp);
    end
    for (int i = 0; i < nResp && i < 3; i++) begin
      e = sbQ.pop_front();
      nCmp++;
      if ({gotE[i], gotD[i]} !== {e.err, e.data}) begin
        nBad++; $display("FAIL hold_valid resp%0d: got err=%b data=%h, expected err=%b data=%h",
                         i, gotE[i], gotD[i], e.err, e.data);
      end
      if (i > 0) begin
        nCmp++;
        if (accE[i] - accE[i-1] !== 4) begin
          nBad++; $display("FAIL hold_valid spacing%0d: got %0d edges, expected 4", i, accE[i] - accE[i-1]);
        end
      end
    end
  endtask

  task automatic test_reset_abort();
    exp_t e;
    logic rvSeen, readyHigh;
    sel = 1'b0; sbQ.delete();
    setReq(0, 1'b1, 32'h20, 32'h0, 4'hF);
    runStream(1);
    @(negedge clk);
    req_write = 1'b1; req_addr = 32'h20; req_wdata = 32'h11111111; req_byte_en = 4'hF;
    valid0 = 1'b1; #1;
    for (int k = 0; k < 10 && ready0 !== 1'b1; k++) begin @(negedge clk); #1; end
    nCmp++;
    if (ready0 !== 1'b1) begin
      nBad++; $display("FAIL abort_accept: ready=%b, expected 1 within 10 cycles", ready0);
      valid0 = 1'b0;
      return;
    end
    @(negedge clk); valid0 = 1'b0;
    @(negedge clk); reset = 1'b1; valid0 = 1'b1; #1;
    nCmp++;
    if ({ready0, busy0} !== 2'b00) begin
      nBad++; $display("FAIL abort_in_reset: ready=%b busy=%b, expected 0 0", ready0, busy0);
    end
    rvSeen = rv0; readyHigh = 1'b0;
    repeat (2) begin
      @(negedge clk); #1;
      rvSeen = rvSeen | rv0;
      readyHigh = readyHigh | ready0;
    end
    reset = 1'b0; valid0 = 1'b0;
    repeat (3) begin @(negedge clk); #1; rvSeen = rvSeen | rv0; end
    nCmp++;
    if ({rvSeen, readyHigh} !== 2'b00) begin
      nBad++; $display("FAIL abort_no_resp: resp_valid seen=%b ready seen=%b, expected 0 0", rvSeen, readyHigh);
    end
    setReq(0, 1'b0, 32'h20, 32'h0, 4'h0); pushExp(32'h0, 1'b0);
    runStream(1);
    nCmp++;
    if (protoBad !== 0) begin nBad++; $display("FAIL abort_load protocol: %0d violations, expected 0", protoBad); end
    if (nResp > 0) begin
      e = sbQ.pop_front();
      nCmp++;
      if ({gotE[0], gotD[0]} !== {e.err, e.data}) begin
        nBad++; $display("FAIL abort_load: got err=%b data=%h, expected err=%b data=%h",
                         gotE[0], gotD[0], e.err, e.data);
      end
    end
  endtask

  task automatic test_back_to_back();
    exp_t e;
    sel = 1'b1; sbQ.delete();
    setReq(0, 1'b1, 32'h40, 32'hCAFEF00D, 4'hF); pushExp(32'h0, 1'b0);
    setReq(1, 1'b0, 32'h40, 32'h0, 4'h0);        pushExp(32'hCAFEF00D, 1'b0);
    runStream(2);
    nCmp++;
    if (protoBad !== 0) begin nBad++; $display("FAIL back_to_back protocol: %0d violations, expected 0", protoBad); end
    for (int i = 0; i < nResp && i < 2; i++) begin
      e = sbQ.pop_front();
      nCmp++;
      if ({gotE[i], gotD[i]} !== {e.err, e.data}) begin
        nBad++; $display("FAIL back_to_back resp%0d: got err=%b data=%h, expected err=%b data=%h",
                         i, gotE[i], gotD[i], e.err, e.data);
      end
    end
    if (nResp == 2) begin
      nCmp++;
      if ({rspE[0] - accE[0], accE[1] - accE[0], rspE[1] - accE[0]} !== {32'd1, 32'd3, 32'd4}) begin
        nBad++; $display("FAIL back_to_back timing: resp0=E+%0d accept1=E+%0d resp1=E+%0d, expected E+1 E+3 E+4",
                         rspE[0] - accE[0], accE[1] - accE[0], rspE[1] - accE[0]);
      end
    end
    sel = 1'b0;
  endtask

  initial begin
    test_reset();
    test_store_load();
    test_byte_lanes();
    test_errors();
    test_hold_valid();
    test_reset_abort();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nBad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation still running at time %0t, expected completion", $time);
    $fatal(1);
  end
endmodule
